// File: rtl/data_memory_sized.sv
// Byte/half/word MIPS data memory with registered loads and little-endian lanes.
// Define DMEM_ALIGN_CHECK_EN to suppress misaligned accesses and record a sticky fault.
module data_memory_sized #(
   parameter int DEPTH_WORDS = 1024,
   parameter int INIT_ZERO   = 1
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   input  logic        MemWrite,
   input  logic        MemRead,
   input  logic [1:0]  Size,
   input  logic        Unsigned,
   output logic [31:0] ReadData,
   output logic        ReadValid,
   output logic        Fault,
   output logic [31:0] FaultAddr
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   logic [AW-1:0] wordIdx;
   logic          misaligned;
   logic          doWrite;
   logic          doRead;
   logic [3:0]    byteEn;
   logic [31:0]   storeWord;
   logic [31:0]   oldWord;
   logic [31:0]   loadValue;
   logic [31:0]   shiftedByte;
   logic [15:0]   loadHalf;
   logic          unusedAddrBits;

   // Address bits above the array span are dropped, so accesses wrap.
   assign wordIdx        = Address[AW+1:2];
   assign unusedAddrBits = ^Address[31:AW+2];

`ifdef DMEM_ALIGN_CHECK_EN
   assign misaligned = (MemRead | MemWrite) &
                       (((Size == 2'b01) & Address[0]) |
                        ((Size == 2'b10) & (Address[1:0] != 2'b00)) |
                        (Size == 2'b11));
`else
   assign misaligned = 1'b0;
`endif

   assign doWrite = MemWrite & ~Reset & ~misaligned;
   assign doRead  = MemRead  & ~Reset & ~misaligned;

   // Store data is replicated across lanes so the lane enables alone pick the target.
   always_comb begin
      byteEn    = 4'b1111;
      storeWord = WriteData;
      case (Size)
         2'b00: begin
            byteEn    = 4'b0001 << Address[1:0];
            storeWord = {4{WriteData[7:0]}};
         end
         2'b01: begin
            byteEn    = Address[1] ? 4'b1100 : 4'b0011;
            storeWord = {2{WriteData[15:0]}};
         end
         default: begin
            byteEn    = 4'b1111;
            storeWord = WriteData;
         end
      endcase
   end

   generate
      if (INIT_ZERO != 0) begin : gInitZero
         logic [31:0] mem [DEPTH_WORDS] = '{default: '0};
         always_ff @(posedge Clk) begin
            if (doWrite) begin
               for (int k = 0; k < 4; k++) begin
                  if (byteEn[k]) mem[wordIdx][8*k +: 8] <= storeWord[8*k +: 8];
               end
            end
         end
         assign oldWord = mem[wordIdx];
      end else begin : gInitUndef
         logic [31:0] mem [DEPTH_WORDS];
         always_ff @(posedge Clk) begin
            if (doWrite) begin
               for (int k = 0; k < 4; k++) begin
                  if (byteEn[k]) mem[wordIdx][8*k +: 8] <= storeWord[8*k +: 8];
               end
            end
         end
         assign oldWord = mem[wordIdx];
      end
   endgenerate

   // oldWord is sampled before the same-edge store lands, giving read-before-write.
   assign shiftedByte = oldWord >> {Address[1:0], 3'b000};
   assign loadHalf    = Address[1] ? oldWord[31:16] : oldWord[15:0];

   always_comb begin
      loadValue = oldWord;
      case (Size)
         2'b00:   loadValue = Unsigned ? {24'h0, shiftedByte[7:0]}
                                       : {{24{shiftedByte[7]}}, shiftedByte[7:0]};
         2'b01:   loadValue = Unsigned ? {16'h0, loadHalf}
                                       : {{16{loadHalf[15]}}, loadHalf};
         default: loadValue = oldWord;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         ReadData  <= 32'h0;
         ReadValid <= 1'b0;
      end else begin
         ReadValid <= doRead;
         if (doRead) ReadData <= loadValue;
      end
   end

`ifdef DMEM_ALIGN_CHECK_EN
   // Only the first fault after reset is recorded.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         Fault     <= 1'b0;
         FaultAddr <= 32'h0;
      end else if (misaligned && !Fault) begin
         Fault     <= 1'b1;
         FaultAddr <= Address;
      end
   end
`else
   assign Fault     = 1'b0;
   assign FaultAddr = 32'h0;
`endif

endmodule
